// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low matrix keypad scanner with whole-scan
// debounce and a 32-bit hex entry shift register.
module keypad_scan #(
  parameter int SCAN_DIV       = 25000,
  parameter int DEBOUNCE_SCANS = 16
) (
  input  logic        clk_axi,
  input  logic        reset,
  input  logic [3:0]  kb_col,
  input  logic        clr,
  output logic [3:0]  kb_row,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_down,
  output logic [31:0] value
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_MAX   = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] DB_ONE   = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } state_t;

  logic [3:0]    col_meta;
  logic [3:0]    col_sync;
  logic [DW-1:0] div_cnt;
  logic [1:0]    row_idx;
  logic          slot_end;

  logic [2:0]    row_hits;
  logic [1:0]    row_col;
  logic [2:0]    hit_sum;
  logic [1:0]    acc_cnt;
  logic [3:0]    acc_code;
  logic [1:0]    scan_cnt;
  logic [3:0]    scan_code;

  logic          res_valid;
  logic [1:0]    res_cnt;
  logic [3:0]    res_code;
  logic          res_none;
  logic          res_single;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] db_cnt;
  logic [CW-1:0] db_n;
  logic [3:0]    cand;
  logic [3:0]    cand_n;
  logic          accept;

  assign slot_end   = (div_cnt == DIV_LAST);
  assign kb_row     = ~(4'b0001 << row_idx);
  assign res_none   = (res_cnt == 2'd0);
  assign res_single = (res_cnt == 2'd1);

  // Hits on the currently driven row.
  always_comb begin
    row_hits = 3'd0;
    row_col  = 2'd0;
    for (int c = 0; c < 4; c++) begin
      if (!col_sync[c]) begin
        row_hits = row_hits + 3'd1;
        row_col  = 2'(c);
      end
    end
  end

  // Running scan total saturates at 2, which already means MULTI.
  always_comb begin
    hit_sum   = {1'b0, acc_cnt} + row_hits;
    scan_cnt  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    scan_code = acc_code;
    if (acc_cnt == 2'd0 && row_hits == 3'd1) begin
      scan_code = {row_idx, row_col};
    end
  end

  always_ff @(posedge clk_axi) begin
    if (reset) begin
      col_meta  <= 4'hF;
      col_sync  <= 4'hF;
      div_cnt   <= '0;
      row_idx   <= 2'd0;
      acc_cnt   <= 2'd0;
      acc_code  <= 4'h0;
      res_valid <= 1'b0;
      res_cnt   <= 2'd0;
      res_code  <= 4'h0;
    end else begin
      col_meta  <= kb_col;
      col_sync  <= col_meta;
      res_valid <= 1'b0;
      if (slot_end) begin
        div_cnt <= '0;
        row_idx <= row_idx + 2'd1;
        if (row_idx == 2'd3) begin
          acc_cnt   <= 2'd0;
          acc_code  <= 4'h0;
          res_valid <= 1'b1;
          res_cnt   <= scan_cnt;
          res_code  <= scan_code;
        end else begin
          acc_cnt  <= scan_cnt;
          acc_code <= scan_code;
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  always_ff @(posedge clk_axi) begin
    if (reset) begin
      state     <= IDLE;
      db_cnt    <= '0;
      cand      <= 4'h0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      value     <= 32'h0;
    end else begin
      state     <= state_n;
      db_cnt    <= db_n;
      cand      <= cand_n;
      key_valid <= accept;
      if (accept) begin
        key_code <= res_code;
        value    <= clr ? {28'h0, res_code}
                        : {value[27:0], res_code};
      end else if (clr) begin
        value <= 32'h0;
      end
    end
  end

  always_comb begin
    state_n = state;
    db_n    = db_cnt;
    cand_n  = cand;
    accept  = 1'b0;
    if (res_valid) begin
      unique case (state)
        IDLE: begin
          if (res_single) begin
            cand_n = res_code;
            if (DEBOUNCE_SCANS == 1) begin
              accept  = 1'b1;
              state_n = HELD;
              db_n    = '0;
            end else begin
              db_n    = DB_ONE;
              state_n = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (res_single && res_code == cand) begin
            if (db_cnt + DB_ONE == DB_MAX) begin
              accept  = 1'b1;
              state_n = HELD;
              db_n    = '0;
            end else begin
              db_n = db_cnt + DB_ONE;
            end
          end else begin
            state_n = IDLE;
            db_n    = '0;
          end
        end
        HELD: begin
          if (res_none) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_n = IDLE;
              db_n    = '0;
            end else begin
              state_n = RELEASE_DB;
              db_n    = DB_ONE;
            end
          end
        end
        RELEASE_DB: begin
          if (res_none) begin
            if (db_cnt + DB_ONE == DB_MAX) begin
              state_n = IDLE;
              db_n    = '0;
            end else begin
              db_n = db_cnt + DB_ONE;
            end
          end else begin
            state_n = HELD;
            db_n    = '0;
          end
        end
        default: begin
          state_n = IDLE;
          db_n    = '0;
        end
      endcase
    end
  end

  always_comb begin
    key_down = (state == HELD) || (state == RELEASE_DB);
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: drives an ideal 4x4 keypad matrix scan by scan and
// checks keypad_scan against a scan-level reference model.
module tb_keypad_scan;

  localparam int SD   = 8;
  localparam int DB   = 3;
  localparam int SCAN = 4 * SD;

  logic        clk_axi = 1'b0;
  logic        reset   = 1'b1;
  logic        clr     = 1'b0;
  logic [3:0]  kb_col;
  logic [3:0]  kb_row;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_down;
  logic [31:0] value;
  logic [15:0] keys = 16'h0;

  int n_cmp = 0;
  int n_err = 0;
  int seen_pulses = 0;

  int          m_run;
  int          m_rel;
  int          m_cand;
  bit          m_held;
  logic [3:0]  m_code;
  logic [31:0] m_value;
  int          m_pulses = 0;

  always #5 clk_axi = ~clk_axi;

  keypad_scan #(
    .SCAN_DIV(SD),
    .DEBOUNCE_SCANS(DB)
  ) dut (
    .clk_axi(clk_axi),
    .reset(reset),
    .kb_col(kb_col),
    .clr(clr),
    .kb_row(kb_row),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_down(key_down),
    .value(value)
  );

  // Ideal switch matrix: a pressed key shorts its row to its column.
  always_comb begin
    kb_col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!kb_row[r] && keys[4*r+c]) kb_col[c] = 1'b0;
      end
    end
  end

  always @(negedge clk_axi) begin
    if (key_valid === 1'b1) seen_pulses++;
  end

  task automatic model_reset();
    m_run   = 0;
    m_rel   = 0;
    m_cand  = 0;
    m_held  = 1'b0;
    m_code  = 4'h0;
    m_value = 32'h0;
  endtask

  // One whole scan of the keypad, judged by the debounce rules.
  task automatic model_scan(input logic [15:0] k, input bit c,
                            output bit acc);
    int n;
    int idx;
    n   = $countones(k);
    idx = 0;
    for (int i = 0; i < 16; i++) if (k[i]) idx = i;
    acc = 1'b0;
    if (!m_held) begin
      if (n == 1 && m_run > 0 && idx == m_cand) m_run++;
      else if (n == 1 && m_run == 0) begin
        m_cand = idx;
        m_run  = 1;
      end else m_run = 0;
      if (m_run == DB) begin
        acc    = 1'b1;
        m_held = 1'b1;
        m_run  = 0;
        m_rel  = 0;
      end
    end else begin
      if (n == 0) m_rel++;
      else m_rel = 0;
      if (m_rel == DB) begin
        m_held = 1'b0;
        m_rel  = 0;
      end
    end
    if (acc) begin
      m_code  = 4'(m_cand);
      m_value = c ? {28'h0, m_code} : {m_value[27:0], m_code};
      m_pulses++;
    end else if (c) begin
      m_value = 32'h0;
    end
  endtask

  // Holds a key set for one scan; returns just after the FSM edge.
  task automatic step(input logic [15:0] k, input bit c, output bit acc);
    keys = k;
    repeat (SCAN - 1) @(posedge clk_axi);
    #1 clr = c;
    @(posedge clk_axi);
    #1 clr = 1'b0;
    model_scan(k, c, acc);
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    repeat (5) @(posedge clk_axi);
    #1;
    model_reset();
    n_cmp++;
    if (kb_row !== 4'b1110) begin
      n_err++;
      $display("FAIL reset_row got %b want 1110", kb_row);
    end
    n_cmp++;
    if ({key_valid, key_code, key_down, value} !== 38'h0) begin
      n_err++;
      $display("FAIL reset_out got v=%b c=%h d=%b val=%h want 0",
               key_valid, key_code, key_down, value);
    end
    reset = 1'b0;
    @(posedge clk_axi);
    #1;
  endtask

  task automatic press_release(input int k);
    bit acc;
    logic [15:0] m;
    m = 16'h0;
    m[k] = 1'b1;
    repeat (DB) step(m, 1'b0, acc);
    n_cmp++;
    if (key_valid !== 1'b1 || key_code !== m_code) begin
      n_err++;
      $display("FAIL entry_key%0d got v=%b c=%h want v=1 c=%h",
               k, key_valid, key_code, m_code);
    end
    repeat (DB) step(16'h0, 1'b0, acc);
  endtask

  task automatic test_reset();
    logic [3:0] want [4];
    bit acc;
    want[0] = 4'b1101;
    want[1] = 4'b1011;
    want[2] = 4'b0111;
    want[3] = 4'b1110;
    do_reset();
    repeat (SD - 1) @(posedge clk_axi);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (kb_row !== want[i]) begin
        n_err++;
        $display("FAIL rotate%0d got %b want %b", i, kb_row, want[i]);
      end
      if (i < 3) repeat (SD) @(posedge clk_axi);
    end
    @(posedge clk_axi);
    #1;
    model_scan(16'h0, 1'b0, acc);
  endtask

  task automatic test_single_press();
    bit acc;
    int first;
    for (int i = 0; i < 6; i++) begin
      step(16'h0040, 1'b0, acc);
      n_cmp++;
      if (key_valid !== acc || key_down !== m_held) begin
        n_err++;
        $display("FAIL press6_s%0d got v=%b d=%b want v=%b d=%b",
                 i, key_valid, key_down, acc, m_held);
      end
    end
    n_cmp++;
    if (key_code !== 4'h6 || value !== 32'h6 || seen_pulses !== 1) begin
      n_err++;
      $display("FAIL press6_res got c=%h val=%h n=%0d want 6 6 1",
               key_code, value, seen_pulses);
    end
    first = -1;
    for (int i = 0; i < 4; i++) begin
      step(16'h0, 1'b0, acc);
      if (key_down === 1'b0 && first < 0) first = i;
      n_cmp++;
      if (key_down !== m_held) begin
        n_err++;
        $display("FAIL release6_s%0d got d=%b want %b",
                 i, key_down, m_held);
      end
    end
    n_cmp++;
    if (first < 0) begin
      n_err++;
      $display("FAIL release6_fall got d=%b want 0 within 4 scans",
               key_down);
    end
  endtask

  task automatic test_entry();
    for (int k = 1; k <= 9; k++) press_release(k);
    n_cmp++;
    if (value !== 32'h23456789 || value !== m_value) begin
      n_err++;
      $display("FAIL entry_value got %h want 23456789", value);
    end
  endtask

  task automatic test_bounce();
    bit acc;
    logic [15:0] pat [9];
    pat = '{16'h0400, 16'h0400, 16'h0, 16'h0400, 16'h0400, 16'h0400,
            16'h0, 16'h0400, 16'h0400};
    for (int i = 0; i < 9; i++) begin
      step(pat[i], 1'b0, acc);
      n_cmp++;
      if (key_valid !== acc || key_valid !== (i == 5)) begin
        n_err++;
        $display("FAIL bounce_s%0d got v=%b want %b",
                 i, key_valid, acc);
      end
    end
    n_cmp++;
    if (key_code !== 4'hA || key_down !== 1'b1) begin
      n_err++;
      $display("FAIL bounce_res got c=%h d=%b want a 1",
               key_code, key_down);
    end
    repeat (DB) step(16'h0, 1'b0, acc);
  endtask

  task automatic test_multi();
    bit acc;
    int pulses0;
    pulses0 = seen_pulses;
    for (int i = 0; i < 5; i++) begin
      step(16'h1008, 1'b0, acc);
      n_cmp++;
      if (key_valid !== 1'b0 || key_down !== 1'b0) begin
        n_err++;
        $display("FAIL multi_s%0d got v=%b d=%b want 0 0",
                 i, key_valid, key_down);
      end
    end
    repeat (DB) step(16'h0020, 1'b0, acc);
    repeat (2) step(16'h0060, 1'b0, acc);
    n_cmp++;
    if (seen_pulses - pulses0 !== 1 || key_code !== 4'h5 ||
        key_down !== 1'b1) begin
      n_err++;
      $display("FAIL multi_add got n=%0d c=%h d=%b want 1 5 1",
               seen_pulses - pulses0, key_code, key_down);
    end
    repeat (DB) step(16'h0, 1'b0, acc);
  endtask

  task automatic test_clr_reset();
    bit acc;
    step(16'h0, 1'b1, acc);
    n_cmp++;
    if (value !== 32'h0) begin
      n_err++;
      $display("FAIL clr_alone got %h want 0", value);
    end
    for (int k = 1; k <= 4; k++) press_release(k);
    n_cmp++;
    if (value !== 32'h1234) begin
      n_err++;
      $display("FAIL clr_pre got %h want 1234", value);
    end
    step(16'h8000, 1'b0, acc);
    step(16'h8000, 1'b0, acc);
    step(16'h8000, 1'b1, acc);
    n_cmp++;
    if (key_valid !== 1'b1 || value !== 32'hF || value !== m_value) begin
      n_err++;
      $display("FAIL clr_accept got v=%b val=%h want 1 0000000f",
               key_valid, value);
    end
    repeat (DB) step(16'h0, 1'b0, acc);
    step(16'h0004, 1'b0, acc);
    keys = 16'h0004;
    do_reset();
    for (int i = 0; i < DB; i++) begin
      step(16'h0004, 1'b0, acc);
      n_cmp++;
      if (key_valid !== acc || key_valid !== (i == DB - 1)) begin
        n_err++;
        $display("FAIL rst_redb_s%0d got v=%b want %b",
                 i, key_valid, acc);
      end
    end
    repeat (DB) step(16'h0, 1'b0, acc);
  endtask

  task automatic test_random();
    bit acc;
    bit c;
    logic [15:0] k;
    k = 16'h0;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        6, 7: k = 16'h0;
        8: begin
          k = 16'h0;
          k[$urandom_range(0, 15)] = 1'b1;
        end
        9: begin
          k = 16'h0;
          k[$urandom_range(0, 7)]  = 1'b1;
          k[$urandom_range(8, 15)] = 1'b1;
        end
        default: ;
      endcase
      c = ($urandom_range(0, 15) == 0);
      step(k, c, acc);
      n_cmp++;
      if (key_valid !== acc || key_down !== m_held ||
          key_code !== m_code || value !== m_value) begin
        n_err++;
        $display("FAIL rand_s%0d got v=%b d=%b c=%h val=%h want v=%b d=%b c=%h val=%h",
                 i, key_valid, key_down, key_code, value,
                 acc, m_held, m_code, m_value);
      end
    end
    repeat (DB) step(16'h0, 1'b0, acc);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_press();
    test_entry();
    test_bounce();
    test_multi();
    test_clr_reset();
    test_random();
    repeat (2) @(posedge clk_axi);
    #1;
    n_cmp++;
    if (seen_pulses !== m_pulses) begin
      n_err++;
      $display("FAIL pulse_total got %0d want %0d", seen_pulses, m_pulses);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
